fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Read-side drain engine for the 8x16 FIFO. It pops 16-bit words from the FIFO read port whenever data is present and serializes each word onto a single line. Each frame is one start bit, 16 data bits LSB first, an optional even-parity bit and one stop bit. It sits directly on the FIFO's `rd_enb`/`rd_data`/`f_empty` signals and is the only reader of that FIFO.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Legal range is 1..255.
- `PARITY_EN`, default 1: when 1, an even-parity bit is inserted after the data bits. When 0, there is no parity bit.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `en`  input  1  permission to start new frames. It is sampled only in IDLE and at the end of STOP.
- `f_empty`  input  1  FIFO empty flag.
- `rd_data`  input  16  FIFO read data. It is registered in the FIFO and valid the cycle after `rd_enb`.
- `rd_enb`  output  1  FIFO pop strobe, one cycle per word.
- `tx`  output  1  serial line; the idle level is 1.
- `busy`  output  1  high whenever the state is not IDLE.
- `frame_cnt`  output  8  count of completed frames; wraps 255 -> 0.

## Operation
- **States:** IDLE, POP, LOAD, START, DATA, PAR, STOP.
- **IDLE:** `tx`=1 and `rd_enb`=0. If `en`=1 and `f_empty`=0 at a rising edge, go to POP.
- **POP:** lasts exactly one cycle with `rd_enb`=1 (`rd_enb` = state==POP). Then go to LOAD.
- **LOAD:** lasts one cycle. `rd_data` is captured into a 16-bit shift register at the end of LOAD. The parity bit is computed as the XOR of the 16 captured bits. Then go to START.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles.
- **DATA:** `tx` = shift register bit 0. The register shifts right once per bit period, for 16 bit periods, tracked by a 4-bit bit index.
- **PAR:** present only if `PARITY_EN`=1. `tx` = parity bit for one bit period.
- **STOP:** `tx`=1 for one bit period. On its last cycle `frame_cnt` increments. Next state:
  - POP if `en`=1 and `f_empty`=0;
  - otherwise IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 within each bit period and is cleared on every state change.
- **No underrun:** POP is entered only when `f_empty` is observed 0, so `rd_enb` is never asserted while the FIFO is empty. No other agent reads the FIFO.
- **`en` deasserted mid-frame:** the current frame completes unchanged, then the block returns to IDLE.
- **`f_empty`** is ignored outside IDLE and the STOP exit decision.
- **Reset:**
  - Asserting `resetn` low at any time, including mid-frame, immediately (asynchronously) forces state=IDLE, `tx`=1, `rd_enb`=0, `busy`=0, `frame_cnt`=0, and clears the shift register, bit index and baud counter.
  - A word already popped is discarded. No partial frame resumes after reset.

## Timing
- **Reset values:** `tx`=1, `rd_enb`=0, `busy`=0, `frame_cnt`=0.
- **Start latency:** let edge E be the edge in IDLE where `en`=1 and `f_empty`=0.
  - The cycle after E is POP (`rd_enb`=1).
  - The next cycle is LOAD.
  - The cycle after that is the first START cycle (`tx`=0).
- **Frame length:** (18 + `PARITY_EN`) × `CLKS_PER_BIT` cycles, from the first START cycle to the last STOP cycle inclusive. With defaults this is 76 cycles.
- **Back-to-back frames:** exactly 2 idle-high cycles (POP, LOAD) separate the last STOP cycle from the next START.
- **`busy`** rises in the POP cycle and falls on the first IDLE cycle.
- **`frame_cnt`** shows the new value in the cycle after the last STOP cycle.
- All outputs except `rd_enb` are registered. `rd_enb` is decoded from the state register only, so it has no combinational path from any input.

## Test plan
- Reset, then hold `en`=0 with the FIFO holding 1 word for 50 cycles -> `tx`=1, `rd_enb` never asserted, `busy`=0, `frame_cnt`=0.
- Defaults, single word 16'hA5C3, `en`=1 -> exactly one `rd_enb` pulse, then `tx` sequence:
  - start bit 0;
  - data bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1;
  - parity 0;
  - stop 1;
  - each bit held 4 cycles, 76 cycles total. `frame_cnt`=1, and the block is back in IDLE with `busy`=0.
- Word 16'h0001 with `PARITY_EN`=1 -> parity bit 1. With `PARITY_EN`=0 -> frame is 72 cycles with no parity bit.
- FIFO full (8 words 16'h0000..16'h0007), `en`=1 ->
  - 8 frames carrying the words in order;
  - exactly 2 idle-high cycles between consecutive frames;
  - exactly 8 `rd_enb` pulses and `rd_enb` never high while `f_empty`=1;
  - `frame_cnt`=8.
- `en` dropped during the DATA bits of frame 1 while 3 words remain -> frame 1 completes intact, no further `rd_enb`, IDLE. Raising `en` again resumes with the next word.
- `resetn` pulsed low for 1 cycle during DATA of frame 3 -> `tx`=1 and `frame_cnt`=0 immediately. After release with `en`=1 and the FIFO non-empty, the next frame starts with POP and carries the next FIFO word.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops 16-bit FIFO words and sends each as start/data/parity/stop.
// clk, resetn, en, f_empty, rd_data in; rd_enb, tx, busy, frame_cnt out.
module fifo_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        f_empty,
  input  logic [15:0] rd_data,
  output logic        rd_enb,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, PAR, STOP
  } state_t;

  state_t      state, state_n;
  logic [15:0] sh, sh_n;
  logic        par, par_n;
  logic [3:0]  bidx, bidx_n;
  logic [7:0]  baud, baud_n;
  logic [7:0]  cnt_n;
  logic        tx_n;
  logic        last;
  logic        timed;

  assign last   = (baud == 8'(CLKS_PER_BIT - 1));
  assign rd_enb = (state == POP);
  assign timed  = (state == START) || (state == DATA) ||
                  (state == PAR)   || (state == STOP);

  always_comb begin
    state_n = state;
    sh_n    = sh;
    par_n   = par;
    bidx_n  = bidx;
    cnt_n   = frame_cnt;
    unique case (state)
      IDLE:  if (en && !f_empty) state_n = POP;
      POP:   state_n = LOAD;
      LOAD: begin
        sh_n    = rd_data;
        par_n   = ^rd_data;
        state_n = START;
      end
      START: if (last) begin
        state_n = DATA;
        bidx_n  = 4'd0;
      end
      DATA: if (last) begin
        sh_n   = {1'b0, sh[15:1]};
        bidx_n = bidx + 4'd1;
        if (bidx == 4'd15)
          state_n = (PARITY_EN != 0) ? PAR : STOP;
      end
      PAR:   if (last) state_n = STOP;
      STOP: if (last) begin
        cnt_n   = frame_cnt + 8'd1;
        state_n = (en && !f_empty) ? POP : IDLE;
      end
      default: state_n = IDLE;
    endcase

    // baud restarts at each bit boundary and each state change
    if (!timed || last || state_n != state)
      baud_n = 8'd0;
    else
      baud_n = baud + 8'd1;

    // tx is registered, so it is derived from the upcoming state
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      PAR:     tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sh        <= 16'd0;
      par       <= 1'b0;
      bidx      <= 4'd0;
      baud      <= 8'd0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      par       <= par_n;
      bidx      <= bidx_n;
      baud      <= baud_n;
      tx        <= tx_n;
      busy      <= (state_n != IDLE);
      frame_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: random-word checks of fifo_serial_tx against a bit-stream model.
// Instance u0 uses parity, u1 has parity disabled; each has its own FIFO model.
module tb_fifo_serial_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0, en2 = 1'b0;
  logic        f_empty = 1'b1, f_empty2 = 1'b1;
  logic [15:0] rd_data = 16'd0, rd_data2 = 16'd0;
  logic        rd_enb, rd_enb2, tx, tx2, busy, busy2;
  logic [7:0]  frame_cnt, frame_cnt2;

  logic [15:0] q[$];
  logic [15:0] q2[$];

  int tests = 0, fails = 0;
  int pops = 0, pops2 = 0, unders = 0;
  int cnt0 = 0, cnt2 = 0;

  always #5 clk = ~clk;

  fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1)) u0 (
    .clk(clk), .resetn(resetn), .en(en), .f_empty(f_empty),
    .rd_data(rd_data), .rd_enb(rd_enb), .tx(tx), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0)) u1 (
    .clk(clk), .resetn(resetn), .en(en2), .f_empty(f_empty2),
    .rd_data(rd_data2), .rd_enb(rd_enb2), .tx(tx2), .busy(busy2),
    .frame_cnt(frame_cnt2)
  );

  // FIFO models: registered read data and registered empty flag
  always @(posedge clk) begin
    if (rd_enb && q.size() > 0) rd_data <= q.pop_front();
    f_empty <= (q.size() == 0);
    if (rd_enb2 && q2.size() > 0) rd_data2 <= q2.pop_front();
    f_empty2 <= (q2.size() == 0);
  end

  always @(negedge clk) begin
    if (rd_enb === 1'b1) begin
      pops++;
      if (f_empty) unders++;
    end
    if (rd_enb2 === 1'b1) begin
      pops2++;
      if (f_empty2) unders++;
    end
  end

  task automatic wait_pop(input bit sel, input int lim,
                          input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if ((sel ? rd_enb2 : rd_enb) === 1'b1) ok = 1'b1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: no rd_enb within %0d cycles, required one", nm, lim);
    end
  endtask

  // called in the POP cycle; checks LOAD then every frame cycle
  task automatic check_frame(input bit sel, input logic [15:0] w,
                             input string nm);
    int   p, nb, bad, first;
    logic e, got, bz, gotf, expf;
    p = sel ? 0 : 1;
    nb = 18 + p;
    bad = 0;
    first = -1;
    gotf = 1'b0;
    expf = 1'b0;
    @(negedge clk);
    got = sel ? tx2 : tx;
    if (got !== 1'b1) begin
      bad++; first = 0; gotf = got; expf = 1'b1;
    end
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                e = 1'b0;
      else if (b <= 16)          e = w[b-1];
      else if (p == 1 && b == 17) e = ^w;
      else                       e = 1'b1;
      for (int c = 0; c < C; c++) begin
        @(negedge clk);
        got = sel ? tx2 : tx;
        bz  = sel ? busy2 : busy;
        if (got !== e || bz !== 1'b1) begin
          if (bad == 0) begin
            first = 1 + b * C + c; gotf = got; expf = e;
          end
          bad++;
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: word %h cycle %0d tx=%b required %b (%0d bad cycles)",
               nm, w, first, gotf, expf, bad);
    end
  endtask

  task automatic after_frame(input bit sel, input bit more,
                             input int cnt, input string nm);
    logic re, bz, t;
    logic [7:0] fc;
    bit ok;
    @(negedge clk);
    re = sel ? rd_enb2 : rd_enb;
    bz = sel ? busy2 : busy;
    t  = sel ? tx2 : tx;
    fc = sel ? frame_cnt2 : frame_cnt;
    if (more) ok = (re === 1'b1) && (bz === 1'b1) && (t === 1'b1);
    else      ok = (re === 1'b0) && (bz === 1'b0) && (t === 1'b1);
    tests++;
    if (!ok || fc !== 8'(cnt)) begin
      fails++;
      $display("FAIL %s: rd_enb=%b busy=%b tx=%b cnt=%0d, required pop=%b cnt=%0d",
               nm, re, bz, t, fc, more, cnt);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    cnt0 = 0;
    cnt2 = 0;
  endtask

  task automatic test_reset();
    int bad;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({tx, rd_enb, busy, frame_cnt} !== {3'b100, 8'd0} ||
        {tx2, rd_enb2, busy2, frame_cnt2} !== {3'b100, 8'd0}) begin
      fails++;
      $display("FAIL reset: tx=%b rd_enb=%b busy=%b cnt=%0d, required 1 0 0 0",
               tx, rd_enb, busy, frame_cnt);
    end
    resetn = 1'b1;
    q.push_back(16'hA5C3);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || rd_enb !== 1'b0 || busy !== 1'b0 ||
          frame_cnt !== 8'd0) bad++;
    end
    tests++;
    if (bad != 0 || pops != 0) begin
      fails++;
      $display("FAIL en_low_hold: %0d bad cycles, %0d pops, required 0 and 0",
               bad, pops);
    end
  endtask

  task automatic test_single();
    bit ok;
    en = 1'b1;
    wait_pop(0, 10, "single_pop", ok);
    if (ok) begin
      check_frame(0, 16'hA5C3, "single_frame");
      cnt0++;
      after_frame(0, 0, cnt0, "single_end");
    end
    tests++;
    if (pops != 1) begin
      fails++;
      $display("FAIL single_pops: %0d pops, required 1", pops);
    end
  endtask

  task automatic test_parity();
    q.push_back(16'h0001);
    q2.push_back(16'h0001);
    en2 = 1'b1;
    fork
      begin
        bit ok0;
        wait_pop(0, 10, "par_on_pop", ok0);
        if (ok0) begin
          check_frame(0, 16'h0001, "par_on_frame");
          cnt0++;
          after_frame(0, 0, cnt0, "par_on_end");
        end
      end
      begin
        bit ok1;
        wait_pop(1, 10, "par_off_pop", ok1);
        if (ok1) begin
          check_frame(1, 16'h0001, "par_off_frame");
          cnt2++;
          after_frame(1, 0, cnt2, "par_off_end");
        end
      end
    join
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    en = 1'b0;
    pulse_reset();
    for (int k = 0; k < 8; k++) q.push_back(16'(k));
    repeat (3) @(negedge clk);
    base = pops;
    en = 1'b1;
    wait_pop(0, 10, "b2b_pop", ok);
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        check_frame(0, 16'(k), "b2b_frame");
        cnt0++;
        after_frame(0, k < 7, cnt0, "b2b_gap");
      end
    end
    tests++;
    if (pops - base != 8 || unders != 0 || frame_cnt !== 8'd8) begin
      fails++;
      $display("FAIL b2b_totals: pops=%0d unders=%0d cnt=%0d, required 8 0 8",
               pops - base, unders, frame_cnt);
    end
  endtask

  task automatic test_en_drop();
    logic [15:0] w[4];
    bit ok;
    int base;
    en = 1'b0;
    foreach (w[i]) begin
      w[i] = 16'($urandom);
      q.push_back(w[i]);
    end
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_pop(0, 10, "drop_pop", ok);
    if (!ok) return;
    fork
      check_frame(0, w[0], "drop_frame");
      begin
        repeat (1 + C + 5 * C) @(negedge clk);
        en = 1'b0;
      end
    join
    cnt0++;
    after_frame(0, 0, cnt0, "drop_end");
    base = pops;
    repeat (20) @(negedge clk);
    tests++;
    if (pops != base || q.size() != 3 || busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_hold: pops=%0d fifo=%0d busy=%b, required 0 3 0",
               pops - base, q.size(), busy);
    end
    en = 1'b1;
    wait_pop(0, 10, "resume_pop", ok);
    if (!ok) return;
    for (int k = 1; k < 4; k++) begin
      check_frame(0, w[k], "resume_frame");
      cnt0++;
      after_frame(0, k < 3, cnt0, "resume_end");
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[5];
    bit ok;
    foreach (w[i]) begin
      w[i] = 16'($urandom);
      q.push_back(w[i]);
    end
    wait_pop(0, 10, "rst_pop", ok);
    if (!ok) return;
    for (int k = 0; k < 2; k++) begin
      check_frame(0, w[k], "rst_pre_frame");
      cnt0++;
      after_frame(0, 1, cnt0, "rst_pre_end");
    end
    repeat (1 + C + 3 * C) @(negedge clk);
    resetn = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || frame_cnt !== 8'd0 || busy !== 1'b0 ||
        rd_enb !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: tx=%b cnt=%0d busy=%b, required 1 0 0",
               tx, frame_cnt, busy);
    end
    cnt0 = 0;
    cnt2 = 0;
    @(negedge clk);
    resetn = 1'b1;
    wait_pop(0, 5, "rst_post_pop", ok);
    if (!ok) return;
    for (int k = 3; k < 5; k++) begin
      check_frame(0, w[k], "rst_post_frame");
      cnt0++;
      after_frame(0, k < 4, cnt0, "rst_post_end");
    end
  endtask

  task automatic test_random_np();
    logic [15:0] w;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      w = 16'($urandom);
      q2.push_back(w);
      wait_pop(1, 10, "rnd_pop", ok);
      if (!ok) return;
      check_frame(1, w, "rnd_frame");
      cnt2++;
      after_frame(1, 0, cnt2, "rnd_end");
    end
    tests++;
    if (unders != 0) begin
      fails++;
      $display("FAIL underrun: %0d pops on empty, required 0", unders);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random_np();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
